// File: rtl/t_pkg.sv
// Shared types and constants for the L/M/R word packer.
package t_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned N_WORDS    = 3;
    localparam int unsigned CNT_W      = 2;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [N_WORDS-1:0]    keep_t;

    // One rebuilt triple as presented to the consumer
    typedef struct packed {
        word_t l;
        word_t m;
        word_t r;
        keep_t keep;
        logic  last;
    } group_t;

    // Keep mask for a group closed with cnt staged words plus the incoming one
    function automatic keep_t keep_mask(input logic [CNT_W-1:0] cnt);
        logic [N_WORDS:0] one_hot;
        one_hot = (N_WORDS+1)'(1) << ({1'b0, cnt} + 3'd1);
        return keep_t'(one_hot - (N_WORDS+1)'(1));
    endfunction

endpackage

// File: rtl/t_word_packer_if.sv
// Serial word input and L/M/R triple output handshake bundle.
interface t_word_packer_if
    import t_pkg::*;
();

    logic  s_valid;
    logic  s_ready;
    word_t s_data;
    logic  s_last;

    logic  m_valid;
    logic  m_ready;
    word_t m_data_l;
    word_t m_data_m;
    word_t m_data_r;
    keep_t m_keep;
    logic  m_last;

    // Environment side: drives the word stream and consumes triples
    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data_l, m_data_m, m_data_r, m_keep, m_last
    );

    // Packer side
    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data_l, m_data_m, m_data_r, m_keep, m_last
    );

endinterface

// File: rtl/t_stage_reg.sv
// Single-word register with asynchronous reset and load enable.
module t_stage_reg
    import t_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en_i,
    input  word_t d_i,
    output word_t q_o
);

    word_t q_q;

    // Capture the word when enabled, clear on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/t_word_packer.sv
// Rebuilds L/M/R word triples with keep mask and packet-end flag from a serial word stream.
module t_word_packer
    import t_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    t_word_packer_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_WORDS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             m_valid_q;
    logic             m_valid_d;
    keep_t            keep_q;
    keep_t            keep_d;
    logic             last_q;
    logic             last_d;

    logic   out_free_c;
    logic   s_ready_c;
    logic   in_fire_c;
    logic   final_c;
    logic   load_out_c;
    logic   stage_en0_c;
    logic   stage_en1_c;
    word_t  stage0;
    word_t  stage1;
    group_t grp_c;

    // Handshake and final-word decode; non-final words bypass output backpressure
    always_comb begin
        out_free_c  = ~m_valid_q | bus.m_ready;
        s_ready_c   = ((cnt_q < CNT_FULL) & ~bus.s_last) | out_free_c;
        in_fire_c   = bus.s_valid & s_ready_c;
        final_c     = (cnt_q == CNT_FULL) | bus.s_last;
        load_out_c  = in_fire_c & final_c;
        stage_en0_c = in_fire_c & ~final_c & (cnt_q == CNT_W'(0));
        stage_en1_c = in_fire_c & ~final_c & (cnt_q == CNT_W'(1));
    end

    // Compose the group closed by the incoming word; unfilled slots read as zero
    always_comb begin
        grp_c      = '0;
        grp_c.keep = keep_mask(cnt_q);
        grp_c.last = bus.s_last;
        case (cnt_q)
            CNT_W'(0): begin
                grp_c.l = bus.s_data;
            end
            CNT_W'(1): begin
                grp_c.l = stage0;
                grp_c.m = bus.s_data;
            end
            default: begin
                grp_c.l = stage0;
                grp_c.m = stage1;
                grp_c.r = bus.s_data;
            end
        endcase
    end

    // Next-state for word count, output valid and output sideband
    always_comb begin
        cnt_d     = cnt_q;
        m_valid_d = m_valid_q;
        keep_d    = keep_q;
        last_d    = last_q;
        if (in_fire_c) begin
            cnt_d = final_c ? '0 : cnt_q + CNT_W'(1);
        end
        if (load_out_c) begin
            m_valid_d = 1'b1;
            keep_d    = grp_c.keep;
            last_d    = grp_c.last;
        end else if (m_valid_q & bus.m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // Control and sideband state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            m_valid_q <= 1'b0;
            keep_q    <= '0;
            last_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            m_valid_q <= m_valid_d;
            keep_q    <= keep_d;
            last_q    <= last_d;
        end
    end

    t_stage_reg u_stage0 (
        .clk  (clk),
        .rst  (rst),
        .en_i (stage_en0_c),
        .d_i  (bus.s_data),
        .q_o  (stage0)
    );

    t_stage_reg u_stage1 (
        .clk  (clk),
        .rst  (rst),
        .en_i (stage_en1_c),
        .d_i  (bus.s_data),
        .q_o  (stage1)
    );

    t_stage_reg u_out_l (
        .clk  (clk),
        .rst  (rst),
        .en_i (load_out_c),
        .d_i  (grp_c.l),
        .q_o  (bus.m_data_l)
    );

    t_stage_reg u_out_m (
        .clk  (clk),
        .rst  (rst),
        .en_i (load_out_c),
        .d_i  (grp_c.m),
        .q_o  (bus.m_data_m)
    );

    t_stage_reg u_out_r (
        .clk  (clk),
        .rst  (rst),
        .en_i (load_out_c),
        .d_i  (grp_c.r),
        .q_o  (bus.m_data_r)
    );

    assign bus.s_ready = s_ready_c;
    assign bus.m_valid = m_valid_q;
    assign bus.m_keep  = keep_q;
    assign bus.m_last  = last_q;

endmodule
